// File: rtl/instr_fetch.sv
// Purpose : single-outstanding instruction fetch unit feeding instr_decode.
// Latency : one cycle from mem_ack to instr_valid; mem_ack may coincide with mem_req rising.
// Backpres: stall holds the presented instruction and suppresses mem_req until it is consumed.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   mem_req/mem_addr  read request and word address (address = internal fetch pc)
//   mem_ack/mem_rdata read completion; only honoured while mem_req=1
//   stall             decoder not ready; keeps instr/instr_pc/instr_valid frozen
//   redirect/_pc      restart fetch at redirect_pc; highest priority after reset
//   instr/instr_pc    fetched word and its address, qualified by instr_valid
//   misaligned        a redirect target was not word aligned; fetch halted
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned
);

  // FETCH: request outstanding. HOLD: instruction presented, waiting for the
  // decoder. HALT: parked after a misaligned redirect.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] instr_pc_nxt;
  logic        instr_valid_nxt;
  logic        misaligned_nxt;
  logic        target_misaligned;

  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  // Request is masked by reset so nothing is issued while the block is being
  // re-initialised, whatever the registered state happens to be.
  assign mem_req  = (state == FETCH) && !reset;
  assign mem_addr = pc;

  // Next-state / datapath. instr and instr_pc only change on a completed
  // fetch (or reset); otherwise they keep their last value and the consumer
  // qualifies them with instr_valid.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    misaligned_nxt  = misaligned;

    if (redirect) begin
      // Overrides any same-cycle ack (data discarded) and any held
      // instruction (consumed if stall=0, flushed otherwise).
      pc_nxt          = redirect_pc;
      instr_valid_nxt = 1'b0;
      misaligned_nxt  = target_misaligned;
      state_nxt       = target_misaligned ? HALT : FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ack) begin
            instr_nxt       = mem_rdata;
            instr_pc_nxt    = pc;
            instr_valid_nxt = 1'b1;
            pc_nxt          = pc + 32'd4;  // wraps modulo 2^32 by width
            state_nxt       = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid_nxt = 1'b0;
            state_nxt       = FETCH;
          end
        end
        HALT: begin
          // Parked until reset or an aligned redirect; acks are ignored
          // because mem_req is low.
        end
        default: begin
          state_nxt       = FETCH;
          instr_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
      misaligned  <= misaligned_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose : self-checking bench for instr_fetch (reference model + directed vectors).
// Latency : n/a (bench).
// Backpres: n/a (bench).
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks what the consumer should see: the next address to fetch, the
  // presented instruction, whether it is still pending, and whether fetch
  // is parked on a bad target.
  logic        m_init = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_valid;
  logic        m_halt;

  always @(posedge clk) begin
    if (reset) begin
      m_init  <= 1'b1;
      m_pc    <= RESET_PC;
      m_instr <= 32'h0;
      m_ipc   <= 32'h0;
      m_valid <= 1'b0;
      m_halt  <= 1'b0;
    end else if (m_init) begin
      if (redirect) begin
        m_pc    <= redirect_pc;
        m_valid <= 1'b0;
        m_halt  <= (redirect_pc % 32'd4) != 32'd0;
      end else if (m_halt) begin
        m_pc <= m_pc;
      end else if (m_valid) begin
        if (!stall) m_valid <= 1'b0;
      end else if (mem_ack) begin
        m_instr <= mem_rdata;
        m_ipc   <= m_pc;
        m_pc    <= m_pc + 32'd4;
        m_valid <= 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare, mid-cycle (inputs settled, registers stable).
  always @(negedge clk) begin
    if (m_init) begin
      logic exp_req;
      exp_req = !reset && !m_valid && !m_halt;
      check("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) check("mem_addr", mem_addr, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
      check("misaligned", 32'(misaligned), 32'(m_halt));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic r, input logic a, input logic [31:0] d,
                        input logic s, input logic rd, input logic [31:0] rp);
    reset       = r;
    mem_ack     = a;
    mem_rdata   = d;
    stall       = s;
    redirect    = rd;
    redirect_pc = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    // Reset values, with reset still asserted.
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_mis", 32'(misaligned), 32'h0);
    check("rst_req_masked", 32'(mem_req), 32'h0);

    // Immediate ack on the first request.
    set_in(1'b0, 1'b1, 32'h7D00_01EF, 1'b0, 1'b0, 32'h0);
    #1;
    check("t1_req", 32'(mem_req), 32'h1);
    check("t1_addr", mem_addr, 32'h0);
    tick();
    check("t1_instr", instr, 32'h7D00_01EF);
    check("t1_ipc", instr_pc, 32'h0);
    check("t1_valid", 32'(instr_valid), 32'h1);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("t1_next_addr", mem_addr, 32'h4);
    check("t1_consumed", 32'(instr_valid), 32'h0);

    // Slow memory (ack after 3 waiting cycles) then 4 stalled cycles.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      check("t2_addr_stable", mem_addr, 32'h4);
      tick();
    end
    set_in(1'b0, 1'b1, 32'hA1A1_0001, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 32'h0);
      #1;
      check("t2_hold_instr", instr, 32'hA1A1_0001);
      check("t2_hold_req", 32'(mem_req), 32'h0);
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("t2_refetch_req", 32'(mem_req), 32'h1);
    check("t2_refetch_addr", mem_addr, 32'h8);

    // Redirect with a same-cycle ack: acked word dropped.
    set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_07D0);
    tick();
    check("t3_no_valid", 32'(instr_valid), 32'h0);
    check("t3_instr_kept", instr, 32'hA1A1_0001);
    check("t3_addr", mem_addr, 32'h7D0);
    set_in(1'b0, 1'b1, 32'hB2B2_0002, 1'b0, 1'b0, 32'h0);
    tick();
    check("t3_ipc", instr_pc, 32'h7D0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // Misaligned redirect halts; ack while halted is ignored.
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
    tick();
    check("t4_mis", 32'(misaligned), 32'h1);
    check("t4_req", 32'(mem_req), 32'h0);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0);
      tick();
      check("t4_halt_valid", 32'(instr_valid), 32'h0);
      check("t4_halt_req", 32'(mem_req), 32'h0);
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    check("t4_mis_clr", 32'(misaligned), 32'h0);
    check("t4_addr", mem_addr, 32'h100);

    // pc wrap at top of address space.
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    set_in(1'b0, 1'b1, 32'hC3C3_0003, 1'b0, 1'b0, 32'h0);
    tick();
    check("t5_ipc", instr_pc, 32'hFFFF_FFFC);
    check("t5_model_pc", m_pc, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("t5_wrap_addr", mem_addr, 32'h0);
    check("t5_mis", 32'(misaligned), 32'h0);

    // Redirect while consuming: no duplicate valid afterwards.
    set_in(1'b0, 1'b1, 32'hD4D4_0004, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    check("t6_valid", 32'(instr_valid), 32'h0);
    check("t6_addr", mem_addr, 32'h200);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("t6_no_dup", 32'(instr_valid), 32'h0);

    // Reset during a stalled HOLD, with redirect/ack/stall also asserted.
    set_in(1'b0, 1'b1, 32'hE5E5_0005, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0300);
    tick();
    check("t7_valid", 32'(instr_valid), 32'h0);
    check("t7_instr", instr, 32'h0);
    check("t7_addr", mem_addr, RESET_PC);

    // Reset mid-fetch: request masked, acked data discarded.
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 32'hF6F6_0006, 1'b0, 1'b0, 32'h0);
    #1;
    check("t8_req_masked", 32'(mem_req), 32'h0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check("t8_valid", 32'(instr_valid), 32'h0);
    check("t8_instr", instr, 32'h0);
    check("t8_req", 32'(mem_req), 32'h1);
    tick();
    set_in(1'b0, 1'b1, 32'h1111_0011, 1'b0, 1'b0, 32'h0);
    tick();
    check("t8_instr_after", instr, 32'h1111_0011);
    check("t8_ipc_after", instr_pc, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
